// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment codes, digit-select encodings and scan FSM states
package seg7_pkg;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [2:0] SEL_ONES     = 3'b001;
  localparam logic [2:0] SEL_TENS     = 3'b010;
  localparam logic [2:0] SEL_HUNDREDS = 3'b100;
  typedef enum logic [1:0] {WAIT_ONES, GOT_ONES, GOT_TENS} state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: maps an active-low a..g segment code to {valid, BCD digit}
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] code_i,
  output logic       valid_o,
  output logic [3:0] digit_o
);
  always_comb begin
    valid_o = 1'b1;
    digit_o = 4'd0;
    case (code_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: synchronizes and debounces a multiplexed 3-digit
// seven-segment scan, then assembles ones/tens/hundreds into a binary value
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [6:0] seg_data,
  input  logic [2:0] seg_select,
  output logic [9:0] value,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic       frame_valid,
  output logic       value_changed,
  output logic       code_error,
  output logic       select_error
);
  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] FULL = 8'(STABLE_CYCLES);
  logic [9:0] sync1_q, sync2_q, prev_q;
  logic [7:0] cnt_q, cnt_d;
  logic       eq, accept, sel_ok, dig_valid;
  logic [2:0] sel;
  logic [3:0] dig;
  logic [9:0] new_value;
  state_t     state_q;
  logic [3:0] ones_q, tens_q, ones_out_q, tens_out_q, hundreds_q;
  logic [9:0] value_q;
  logic       frame_valid_q, value_changed_q, code_error_q, select_error_q;
  // Counter saturates at FULL so a held pair is accepted exactly once.
  assign eq     = sync2_q == prev_q;
  assign cnt_d  = !eq ? 8'd0 : (cnt_q == FULL ? cnt_q : cnt_q + 8'd1);
  assign accept = eq && cnt_q == LAST;
  assign sel    = sync2_q[9:7];
  assign sel_ok = sel == SEL_ONES || sel == SEL_TENS || sel == SEL_HUNDREDS;
  assign new_value = {6'd0, dig} * 10'd100 + {6'd0, tens_q} * 10'd10 + {6'd0, ones_q};
  seg7_decode u_decode (
    .code_i  (sync2_q[6:0]),
    .valid_o (dig_valid),
    .digit_o (dig)
  );
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= {seg_select, seg_data};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q         <= WAIT_ONES;
      ones_q          <= '0;
      tens_q          <= '0;
      ones_out_q      <= '0;
      tens_out_q      <= '0;
      hundreds_q      <= '0;
      value_q         <= '0;
      frame_valid_q   <= 1'b0;
      value_changed_q <= 1'b0;
      code_error_q    <= 1'b0;
      select_error_q  <= 1'b0;
    end else begin
      frame_valid_q   <= 1'b0;
      value_changed_q <= 1'b0;
      code_error_q    <= 1'b0;
      select_error_q  <= 1'b0;
      if (accept) begin
        if (!dig_valid || !sel_ok) begin
          code_error_q   <= !dig_valid;
          select_error_q <= !sel_ok;
          state_q        <= WAIT_ONES;
        end else if (sel == SEL_ONES) begin
          ones_q  <= dig;
          state_q <= GOT_ONES;
        end else if (sel == SEL_TENS && state_q == GOT_ONES) begin
          tens_q  <= dig;
          state_q <= GOT_TENS;
        end else if (sel == SEL_HUNDREDS && state_q == GOT_TENS) begin
          value_q         <= new_value;
          hundreds_q      <= dig;
          tens_out_q      <= tens_q;
          ones_out_q      <= ones_q;
          frame_valid_q   <= 1'b1;
          value_changed_q <= new_value != value_q;
          state_q         <= WAIT_ONES;
        end else begin
          state_q <= WAIT_ONES;
        end
      end
    end
  end
  assign value         = value_q;
  assign ones          = ones_out_q;
  assign tens          = tens_out_q;
  assign hundreds      = hundreds_q;
  assign frame_valid   = frame_valid_q;
  assign value_changed = value_changed_q;
  assign code_error    = code_error_q;
  assign select_error  = select_error_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed and random scans against a run-length and
// partial-frame reference model
module tb_seg7_scan_decoder;
  localparam int S = 4;
  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_data = 7'h7f;
  logic [2:0] seg_select = 3'b000;
  logic [9:0] value;
  logic [3:0] ones, tens, hundreds;
  logic       frame_valid, value_changed, code_error, select_error;
  always #5 sysclk = ~sysclk;
  seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .sysclk        (sysclk),
    .rst           (rst),
    .seg_data      (seg_data),
    .seg_select    (seg_select),
    .value         (value),
    .ones          (ones),
    .tens          (tens),
    .hundreds      (hundreds),
    .frame_valid   (frame_valid),
    .value_changed (value_changed),
    .code_error    (code_error),
    .select_error  (select_error)
  );
  typedef struct {int at; logic [9:0] p;} acc_t;
  logic [6:0] codes [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  acc_t       pend [$];
  int         part [$];
  logic [9:0] cur = '0;
  int total = 0, bad = 0, cyc = 0, run = 0, start = 0;
  int hv = 0, fv_cnt = 0, vc_cnt = 0, ce_cnt = 0, se_cnt = 0;
  int hd [3] = '{0, 0, 0};
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, cyc);
    end
  endtask
  function automatic int dec(input logic [6:0] c);
    for (int i = 0; i < 10; i++) if (codes[i] == c) return i;
    return -1;
  endfunction
  // Expected pulses as {frame_valid, value_changed, code_error, select_error}.
  task automatic apply(input logic [9:0] p, output int ep);
    int d, nv;
    logic [2:0] s;
    bit sok;
    d = dec(p[6:0]);
    s = p[9:7];
    sok = s == 3'd1 || s == 3'd2 || s == 3'd4;
    ep = 0;
    if (d < 0 || !sok) begin
      ep = (d < 0 ? 2 : 0) | (sok ? 0 : 1);
      part.delete();
    end else if (s == 3'd1) begin
      part.delete();
      part.push_back(d);
    end else if (s == 3'd2) begin
      if (part.size() == 1) part.push_back(d);
      else part.delete();
    end else begin
      if (part.size() == 2) begin
        nv = d * 100 + part[1] * 10 + part[0];
        ep = 8 | (nv != hv ? 4 : 0);
        hv = nv;
        hd = '{part[0], part[1], d};
      end
      part.delete();
    end
  endtask
  task automatic monitor();
    int ep = 0;
    if (pend.size() > 0 && pend[0].at == cyc) begin
      apply(pend[0].p, ep);
      void'(pend.pop_front());
    end
    chk("pulses", int'({frame_valid, value_changed, code_error, select_error}), ep);
    chk("value", int'(value), hv);
    chk("digits", int'({hundreds, tens, ones}), hd[2] * 256 + hd[1] * 16 + hd[0]);
    fv_cnt += int'(frame_valid);
    vc_cnt += int'(value_changed);
    ce_cnt += int'(code_error);
    se_cnt += int'(select_error);
  endtask
  // A pair driven for S+1 consecutive cycles is accepted; effect shows S+2 edges after it is first captured.
  task automatic tick(input logic [9:0] p);
    {seg_select, seg_data} = p;
    if (!rst) begin
      if (p != cur) begin
        cur = p;
        run = 1;
        start = cyc + 1;
      end else run++;
      if (run == S + 1) pend.push_back('{start + S + 2, p});
    end
    @(posedge sysclk);
    cyc++;
    @(negedge sysclk);
    monitor();
  endtask
  task automatic hold(input logic [9:0] p, input int n);
    repeat (n) tick(p);
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    pend.delete();
    part.delete();
    hv = 0;
    hd = '{0, 0, 0};
    cur = '0;
    run = 0;
    repeat (n) tick({seg_select, seg_data});
    rst = 1'b0;
  endtask
  task automatic scan(input int h, input int t, input int o, input int n);
    hold({3'b001, codes[o]}, n);
    hold({3'b010, codes[t]}, n);
    hold({3'b100, codes[h]}, n);
  endtask
  function automatic logic [9:0] rnd_pair();
    logic [9:0] p;
    do begin
      p[9:7] = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'(1 << $urandom_range(0, 2));
      p[6:0] = ($urandom_range(0, 5) == 0) ? 7'($urandom) : codes[$urandom_range(0, 9)];
    end while (p == 10'd0);
    return p;
  endfunction
  initial begin
    int f0, c0, s0, v0;
    @(negedge sysclk);
    do_reset(3);
    chk("reset_value", int'(value), 0);
    f0 = fv_cnt; v0 = vc_cnt;
    scan(1, 3, 9, 10);
    chk("scan139_fv", fv_cnt - f0, 1);
    chk("scan139_vc", vc_cnt - v0, 1);
    chk("scan139_val", int'(value), 139);
    f0 = fv_cnt; v0 = vc_cnt;
    scan(1, 3, 9, 10);
    chk("rep139_fv", fv_cnt - f0, 1);
    chk("rep139_vc", vc_cnt - v0, 0);
    f0 = fv_cnt; c0 = ce_cnt;
    hold({3'b001, codes[8]}, 10);
    hold({3'b010, 7'b1111110}, 10);
    chk("badcode_ce", ce_cnt - c0, 1);
    chk("badcode_fv", fv_cnt - f0, 0);
    scan(9, 9, 9, 10);
    chk("scan999_val", int'(value), 999);
    s0 = se_cnt;
    hold({3'b011, codes[5]}, 10);
    chk("badsel_se", se_cnt - s0, 1);
    hold({3'b001, codes[5]}, 10);
    s0 = se_cnt;
    hold({3'b011, codes[5]}, S - 1);
    hold({3'b001, codes[5]}, 10);
    chk("glitch_se", se_cnt - s0, 0);
    f0 = fv_cnt;
    hold({3'b001, codes[7]}, 10);
    hold({3'b010, codes[6]}, 10);
    do_reset(2);
    hold({3'b100, codes[3]}, 10);
    chk("rstmid_fv", fv_cnt - f0, 0);
    chk("rstmid_val", int'(value), 0);
    f0 = fv_cnt; v0 = vc_cnt;
    hold({3'b001, codes[2]}, 10);
    hold({3'b100, codes[4]}, 10);
    chk("skip_fv", fv_cnt - f0, 0);
    scan(0, 0, 0, 10);
    chk("zero_fv", fv_cnt - f0, 1);
    chk("zero_vc", vc_cnt - v0, 0);
    chk("zero_val", int'(value), 0);
    for (int n = 0; n < 300; n++) begin
      int r = $urandom_range(0, 19);
      if (r == 0) do_reset($urandom_range(1, 3));
      else if (r < 9) scan($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(S + 1, S + 4));
      else hold(rnd_pair(), $urandom_range(1, S + 3));
    end
    hold({seg_select, seg_data}, S + 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
